mmio_bus_arbiter: RTL
=====================

# mmio_bus_arbiter

Round-robin arbiter that shares the single FPro MMIO bus between N_REQ bus requesters, for example the CPU, a DMA engine and a debug bridge. It sits between the requesters and the MMIO controller's `mmio_*` input ports. It serializes accesses into one-cycle MMIO transactions, captures read data, and returns a one-hot acknowledge to the winning requester.

## Interface
- `N_REQ`, 4: number of requesters; must be 2–8.
- `AW`, 21: MMIO address width; matches the FPro `mmio_addr`.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset (0 = reset asserted).
- `req` in N_REQ: per-requester access request; held high until the matching `ack`.
- `req_wr` in N_REQ: per-requester access type; 1 = write, 0 = read.
- `req_addr` in N_REQ×AW: packed per-requester address; slice i is `[i*AW +: AW]`.
- `req_wr_data` in N_REQ×32: packed per-requester write data.
- `ack` out N_REQ: one-hot, one-cycle completion pulse.
- `rd_data` out 32: read data, valid in the `ack` cycle of a read.
- `grant_id` out clog2(N_REQ): index of the most recently granted requester.
- `busy` out 1: high in ACCESS and ACK.
- `mmio_cs`, `mmio_wr`, `mmio_rd` out 1 each: MMIO bus controls.
- `mmio_addr` out AW: MMIO address.
- `mmio_wr_data` out 32: MMIO write data.
- `mmio_rd_data` in 32: combinational read return from the MMIO controller.

## Operation
- Finite-state machine (FSM) states are IDLE, ACCESS and ACK. Reset state is IDLE.
- **IDLE:** if any `req` bit is high, pick a winner by round-robin starting at `last_grant+1` (mod N_REQ).
  - Latch the winner's `req_wr`, `req_addr` and `req_wr_data` into the bus output registers.
  - Set `last_grant` and `grant_id` to the winner, then go to ACCESS.
  - If no `req` bit is high, stay in IDLE with all `mmio_*` controls at 0.
- **ACCESS:**
  - Drive `mmio_cs`=1.
  - Drive `mmio_wr`=latched wr, `mmio_rd`=!latched wr.
  - Drive `mmio_addr` and `mmio_wr_data` from the latches.
  - On a read, register `mmio_rd_data` into `rd_data` at the end of the cycle.
  - Then go to ACK.
- **ACK:** pulse `ack[grant_id]`=1 with all `mmio_*` controls at 0, then go to IDLE. No arbitration is performed in ACK.
- `rd_data` holds its value until the next read completes. Writes do not modify it.
- `mmio_wr` and `mmio_rd` are never both 1. Neither is ever 1 while `mmio_cs`=0.
- Requester obligations:
  - Keep `req_wr`, `req_addr` and `req_wr_data` stable from raising `req` until `ack`.
  - Drop `req` in the cycle after `ack`, or keep it high to request another access.
- Withdrawing `req` before it is sampled in IDLE cancels the request. Once latched, an access is committed and always completes with `ack`, even if `req` drops.
- `last_grant` resets to N_REQ-1, so requester 0 has first priority after reset.

## Timing
- Latency from `req` sampled in IDLE to `mmio_cs` high is 1 cycle. From `req` to `ack` it is 2 cycles.
- Throughput is one access every 3 cycles under continuous demand.
- A requester waits at most N_REQ-1 other accesses before it is served.
- All outputs are registered. `ack` and `rd_data` are captured in the same cycle.
- **Reset values:**
  - `mmio_cs`, `mmio_wr`, `mmio_rd` = 0.
  - `mmio_addr`, `mmio_wr_data`, `rd_data` = 0.
  - `ack` = 0, `busy` = 0, `grant_id` = 0.
  - `last_grant` = N_REQ-1.
- Reset asserted mid-access clears all outputs asynchronously and returns the FSM to IDLE. The in-flight access is lost without an `ack`.
- Simultaneous requests are resolved only by the round-robin pointer. No fixed priority applies beyond reset.

## Structure
- Package `mmio_arb_pkg`:
  - `arb_state_t` enum {IDLE, ACCESS, ACK}.
  - Function `rr_pick(req, last)`, returning the winner index and a valid flag.
- Sub-module `mmio_rr_pick`: combinational round-robin selector, parameterized by N_REQ. It is instantiated once.
- The top level holds the FSM, the command latches and the `rd_data` register.

## Test plan
1. **Single write:** after reset, requester 1 raises `req` with wr=1, addr=0x00A02, data=0xDEADBEEF.
   - Next cycle: `mmio_cs`=1, `mmio_wr`=1, `mmio_addr`=0x00A02, `mmio_wr_data`=0xDEADBEEF.
   - Cycle after: `ack`=4'b0010, and `rd_data` is still 0.
2. **Read capture:** requester 0 reads addr 0x00060 while the bench drives `mmio_rd_data`=0x12345678 in ACCESS.
   - In the ACK cycle, `rd_data`=0x12345678 and `ack`=4'b0001.
   - `mmio_rd_data` later set to 0xFFFFFFFF leaves `rd_data` unchanged.
3. **Continuous demand:** all four `req` bits are held high from reset.
   - `ack` sequence is 0001, 0010, 0100, 1000, 0001, with one `ack` every 3 cycles.
4. **Pointer-based resolution:** after requester 1 is granted, requesters 0 and 2 raise `req` in the same cycle.
   - Requester 2 is served first, then requester 0.
5. **Reset mid-access:** assert `reset`=0 during ACCESS.
   - All outputs go to 0 immediately and no `ack` is issued.
   - After release with requester 3's `req` still high: access proceeds, `ack`=4'b1000 two cycles later.
6. **Withdraw and commit:**
   - Requester 2 pulses `req` for 0 cycles in IDLE, i.e. drops it before it is sampled: no bus activity results.
   - Requester 2 drops `req` during ACCESS: `ack`=4'b0100 is still issued.

Source files
------------

// File: rtl/mmio_arb_pkg.sv
// mmio_arb_pkg
// Shared types and helpers for the MMIO bus arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ACCESS, ACK)
//   rr_pick_t   : result of a round-robin pick (valid flag + winner index)
//   rr_pick()   : round-robin search over up to MAX_REQ request lines
package mmio_arb_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } arb_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_pick_t;

    // Searches from last+1 upward (mod n). The loop runs from the farthest
    // candidate down to the nearest one, so the nearest requester after the
    // pointer is the one left in the result.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         last,
        input int                 n
    );
        rr_pick_t   result;
        int         cand;
        logic [2:0] cand_idx;
        result = '0;
        for (int k = n; k >= 1; k--) begin
            cand     = (int'(last) + k) % n;
            cand_idx = 3'(cand);
            if (req[cand_idx]) begin
                result.valid = 1'b1;
                result.idx   = cand_idx;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mmio_rr_pick.sv
// mmio_rr_pick
// Combinational round-robin selector.
//   req    : request vector, one bit per requester
//   last   : index of the most recently granted requester
//   valid  : at least one request is pending
//   winner : index of the requester to serve next
module mmio_rr_pick
    import mmio_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             valid,
    output logic [IW-1:0]    winner
);

    rr_pick_t pick;

    // The package helper works on an 8-wide vector; the winner index is
    // mapped back by comparison so that every bit of the pick is examined.
    always_comb begin
        pick   = rr_pick(MAX_REQ'(req), 3'(last), N_REQ);
        valid  = pick.valid;
        winner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick.idx == 3'(i)) begin
                winner = IW'(i);
            end
        end
    end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter
// Round-robin arbiter sharing one FPro MMIO bus among N_REQ (2..8) requesters.
// Each access runs IDLE -> ACCESS -> ACK: one bus cycle, then a one-hot ack.
//   clk, reset         : clock, asynchronous active-low reset
//   req/req_wr         : per-requester request and access type (1 = write)
//   req_addr           : packed addresses, slice i at [i*AW +: AW]
//   req_wr_data        : packed write data, slice i at [i*32 +: 32]
//   ack                : one-hot completion pulse
//   rd_data            : read data, valid with ack of a read, held otherwise
//   grant_id           : most recently granted requester
//   busy               : high during ACCESS and ACK
//   mmio_*             : registered MMIO bus towards the controller
//   mmio_rd_data       : combinational read return from the controller
module mmio_bus_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int AW    = 21,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_wr,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*32-1:0] req_wr_data,
    output logic [N_REQ-1:0]    ack,
    output logic [31:0]         rd_data,
    output logic [IW-1:0]       grant_id,
    output logic                busy,
    output logic                mmio_cs,
    output logic                mmio_wr,
    output logic                mmio_rd,
    output logic [AW-1:0]       mmio_addr,
    output logic [31:0]         mmio_wr_data,
    input  logic [31:0]         mmio_rd_data
);

    arb_state_t    state;
    arb_state_t    state_next;
    logic [IW-1:0] last_grant;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          load_cmd;

    mmio_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req    (req),
        .last   (last_grant),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state. Arbitration only happens in IDLE, so a request that drops
    // before it is sampled there is simply never seen.
    always_comb begin
        state_next = state;
        load_cmd   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    load_cmd   = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered bus outputs, command latches and read-data capture.
    // The bus controls registered at the IDLE->ACCESS edge are exactly the
    // ones driven during ACCESS; mmio_rd being high there marks a read whose
    // data is captured together with the ack. Address and write data are
    // left holding after the access since only the controls qualify them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mmio_cs      <= 1'b0;
            mmio_wr      <= 1'b0;
            mmio_rd      <= 1'b0;
            mmio_addr    <= '0;
            mmio_wr_data <= '0;
            rd_data      <= '0;
            ack          <= '0;
            busy         <= 1'b0;
            grant_id     <= '0;
            last_grant   <= IW'(N_REQ - 1);
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (load_cmd) begin
                        mmio_cs      <= 1'b1;
                        mmio_wr      <= req_wr[pick_idx];
                        mmio_rd      <= !req_wr[pick_idx];
                        mmio_addr    <= req_addr[pick_idx*AW +: AW];
                        mmio_wr_data <= req_wr_data[pick_idx*32 +: 32];
                        grant_id     <= pick_idx;
                        last_grant   <= pick_idx;
                        busy         <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (mmio_rd) begin
                        rd_data <= mmio_rd_data;
                    end
                    ack[grant_id] <= 1'b1;
                    mmio_cs       <= 1'b0;
                    mmio_wr       <= 1'b0;
                    mmio_rd       <= 1'b0;
                end
                ACK: begin
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
